// File: rtl/bnn_core_feeder.sv
// Row-streaming sequencer feeding a bnn_core: reads the binarized feature map once per
// output channel, presents channel-interleaved rows with the matching kernel and calc enables.
module bnn_core_feeder #(
    parameter int IN_CHANNEL    = 3,
    parameter int OUT_CHANNEL   = 3,
    parameter int WEGT_WIDTH    = 3,
    parameter int IN_DATA_WIDTH = 28,
    parameter int CORE_DELAY    = 5,
    parameter int WEGT_SIZE     = WEGT_WIDTH * WEGT_WIDTH * IN_CHANNEL,
    parameter int ADDR_WIDTH    = $clog2(IN_DATA_WIDTH * IN_CHANNEL)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             i_start,
    input  logic [OUT_CHANNEL*WEGT_SIZE-1:0] i_weights,
    output logic                             o_rd_en,
    output logic [ADDR_WIDTH-1:0]            o_rd_addr,
    input  logic [IN_DATA_WIDTH-1:0]         i_rd_data,
    output logic [IN_DATA_WIDTH-1:0]         o_data,
    output logic                             o_valid,
    output logic [WEGT_SIZE-1:0]             o_weight,
    output logic [CORE_DELAY-1:0]            o_calc_valid,
    output logic [1:0]                       o_oc_idx,
    output logic                             o_busy,
    output logic                             o_done
);

    // state | meaning
    // IDLE  | waiting for i_start
    // READ  | one row-memory read per cycle, ch fastest
    // GAP   | one idle cycle between passes so the core's channel counter resets
    // DRAIN | last pass read; waiting for valid and calc pipeline to empty
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {IDLE, READ, GAP, DRAIN, DONE} state_t;

    localparam int RW = $clog2(IN_DATA_WIDTH);
    localparam logic [1:0]    CH_LAST  = 2'(IN_CHANNEL - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_DATA_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(WEGT_WIDTH - 1);
    localparam logic [1:0]    OC_LAST  = 2'(OUT_CHANNEL - 1);

    state_t state, state_nxt;

    logic [1:0]    ch;
    logic [RW-1:0] row;
    logic [1:0]    oc;
    logic [1:0]    v_ch;
    logic [RW-1:0] v_row;
    logic          calc0;
    logic [CORE_DELAY-1:1] calc_q;
    logic          last_read;
    logic          pipe_empty;

    logic [WEGT_SIZE-1:0] kern [OUT_CHANNEL];

    // Output channel 0 lives in the MSB slice of i_weights.
    for (genvar i = 0; i < OUT_CHANNEL; i++) begin : g_kern
        assign kern[i] = i_weights[(OUT_CHANNEL-1-i)*WEGT_SIZE +: WEGT_SIZE];
    end

    assign last_read  = (ch == CH_LAST) && (row == ROW_LAST);
    // calc_q's top bit shifts out on this edge, so only the lower stages must be clear.
    assign pipe_empty = !o_valid && (calc_q[CORE_DELAY-2:1] == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (i_start) state_nxt = READ;
            READ:  if (last_read) state_nxt = (oc == OC_LAST) ? DRAIN : GAP;
            GAP:   state_nxt = READ;
            DRAIN: if (pipe_empty) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_rd_en = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state)
            READ:  begin o_rd_en = 1'b1; o_busy = 1'b1; end
            GAP:   o_busy = 1'b1;
            DRAIN: o_busy = 1'b1;
            DONE:  begin o_busy = 1'b1; o_done = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch  <= '0;
            row <= '0;
            oc  <= '0;
        end else begin
            if (state == READ) begin
                if (ch == CH_LAST) begin
                    ch  <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    ch <= ch + 1'b1;
                end
            end
            if (state == GAP)  oc <= oc + 1'b1;
            if (state == DONE) oc <= '0;
        end
    end

    // New kernel lands together with the first valid row of its pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_weight <= '0;
        end else if (state == READ && row == '0 && ch == '0) begin
            o_weight <= kern[oc];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_valid <= 1'b0;
            v_ch    <= '0;
            v_row   <= '0;
            calc_q  <= '0;
        end else begin
            o_valid <= o_rd_en;
            v_ch    <= ch;
            v_row   <= row;
            calc_q  <= {calc_q[CORE_DELAY-2:1], calc0};
        end
    end

    assign calc0        = o_valid && (v_ch == CH_LAST) && (v_row >= ROW_MIN);
    assign o_calc_valid = {calc_q, calc0};
    assign o_data       = i_rd_data;
    assign o_oc_idx     = oc;
    assign o_rd_addr    = ADDR_WIDTH'(row) * ADDR_WIDTH'(IN_CHANNEL) + ADDR_WIDTH'(ch);

endmodule

// File: tb/tb_bnn_core_feeder.sv
// Directed bench for bnn_core_feeder: full passes, restart-ignore, mid-pass async reset.
module tb_bnn_core_feeder;

    localparam int WS = 27;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_start;
    logic [3*WS-1:0] i_weights;
    logic          o_rd_en;
    logic [6:0]    o_rd_addr;
    logic [27:0]   i_rd_data;
    logic [27:0]   o_data;
    logic          o_valid;
    logic [WS-1:0] o_weight;
    logic [4:0]    o_calc_valid;
    logic [1:0]    o_oc_idx;
    logic          o_busy;
    logic          o_done;

    int checks = 0;
    int errors = 0;

    bnn_core_feeder dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_weights(i_weights),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .o_data(o_data), .o_valid(o_valid), .o_weight(o_weight),
        .o_calc_valid(o_calc_valid), .o_oc_idx(o_oc_idx), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] mem_word(input int a);
        return 28'(a * 32'h0013579) ^ 28'hA5C3000;
    endfunction

    // Synchronous row memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (o_rd_en) i_rd_data <= mem_word(int'(o_rd_addr));
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit exp_en(input int c);
        return (c >= 1 && c <= 84) || (c >= 86 && c <= 169) || (c >= 171 && c <= 254);
    endfunction

    function automatic int exp_addr(input int c);
        if (c <= 84)  return c - 1;
        if (c <= 169) return c - 86;
        return c - 171;
    endfunction

    function automatic int exp_pass(input int c);
        if (c <= 85)  return 0;
        if (c <= 170) return 1;
        return 2;
    endfunction

    function automatic bit exp_c0(input int c);
        for (int p = 0; p < 3; p++)
            for (int r = 2; r < 28; r++)
                if (c == 85*p + 3*r + 4) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_rd_en"}, 64'(o_rd_en), 64'd0);
        check_val({tag, "_valid"}, 64'(o_valid), 64'd0);
        check_val({tag, "_busy"},  64'(o_busy),  64'd0);
        check_val({tag, "_done"},  64'(o_done),  64'd0);
        check_val({tag, "_calc"},  64'(o_calc_valid), 64'd0);
        check_val({tag, "_addr"},  64'(o_rd_addr), 64'd0);
        check_val({tag, "_oc"},    64'(o_oc_idx), 64'd0);
        check_val({tag, "_weight"}, 64'(o_weight), 64'd0);
    endtask

    // Start a pass at cycle 0 and observe cycles 1..ncyc against the timing model.
    task automatic run_pass(input int dup_cyc, input int abort_cyc, input int ncyc);
        int rd_cnt = 0, addr_err = 0, en_err = 0, busy_err = 0, oc_err = 0;
        int done_cnt = 0, done_at = -1, w_err = 0, d_err = 0, v_err = 0;
        int calc_err = 0, first_c0 = -1;
        int calc_cnt [5] = '{0, 0, 0, 0, 0};
        logic [WS-1:0] w_exp [3];
        w_exp[0] = i_weights[3*WS-1:2*WS];
        w_exp[1] = i_weights[2*WS-1:WS];
        w_exp[2] = i_weights[WS-1:0];

        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (abort_cyc != 0 && c == abort_cyc) begin
                check_val("abort_busy_before", 64'(o_busy), 64'd1);
                reset_n = 1'b0;
                #1;
                check_idle_outputs("abort");
                return;
            end
            if (c == 1) check_val("first_addr", 64'(o_rd_addr), 64'd0);
            if (o_rd_en !== exp_en(c)) en_err++;
            if (o_rd_en) begin
                rd_cnt++;
                if (int'(o_rd_addr) != exp_addr(c)) addr_err++;
                if (int'(o_oc_idx) != exp_pass(c)) oc_err++;
            end
            if (o_valid !== exp_en(c-1)) v_err++;
            if (o_valid && exp_en(c-1) && o_data !== mem_word(exp_addr(c-1))) d_err++;
            if (o_busy !== (c >= 1 && c <= 260)) busy_err++;
            if (o_done) begin
                done_cnt++;
                done_at = c;
            end
            for (int k = 0; k < 5; k++) begin
                if (o_calc_valid[k] !== exp_c0(c-k)) calc_err++;
                if (o_calc_valid[k]) calc_cnt[k]++;
            end
            if (o_calc_valid[0] && first_c0 < 0) first_c0 = c;
            if ((c >= 2 && c <= 85) && o_weight !== w_exp[0]) w_err++;
            if ((c >= 87 && c <= 170) && o_weight !== w_exp[1]) w_err++;
            if ((c >= 172 && c <= 260) && o_weight !== w_exp[2]) w_err++;
            i_start = (c == dup_cyc);
            tick();
        end
        i_start = 1'b0;
        check_val("rd_count", 64'(rd_cnt), 64'd252);
        check_val("rd_en_pattern", 64'(en_err), 64'd0);
        check_val("addr_seq", 64'(addr_err), 64'd0);
        check_val("oc_idx", 64'(oc_err), 64'd0);
        check_val("valid_delay", 64'(v_err), 64'd0);
        check_val("data_pass", 64'(d_err), 64'd0);
        check_val("busy_window", 64'(busy_err), 64'd0);
        check_val("done_count", 64'(done_cnt), 64'd1);
        check_val("done_cycle", 64'(done_at), 64'd260);
        check_val("calc_pattern", 64'(calc_err), 64'd0);
        check_val("first_calc0", 64'(first_c0), 64'd10);
        for (int k = 0; k < 5; k++) check_val($sformatf("calc%0d_count", k), 64'(calc_cnt[k]), 64'd78);
        check_val("weight_seq", 64'(w_err), 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        i_start   = 1'b1;
        i_weights = {27'h7FFFFFF, 27'h0000000, 27'h5555555};
        repeat (3) tick();
        check_idle_outputs("reset");
        i_start = 1'b0;
        reset_n = 1'b1;
        repeat (3) tick();
        check_val("no_start_rd_en", 64'(o_rd_en), 64'd0);
        check_val("no_start_busy", 64'(o_busy), 64'd0);

        run_pass(100, 0, 270);
        tick();
        check_val("post_done_busy", 64'(o_busy), 64'd0);
        check_val("post_done_oc", 64'(o_oc_idx), 64'd0);

        run_pass(0, 120, 270);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        check_val("post_abort_rd_en", 64'(o_rd_en), 64'd0);
        check_val("post_abort_done", 64'(o_done), 64'd0);

        i_weights = {27'h1234567, 27'h7654321, 27'h0ABCDEF};
        run_pass(0, 0, 270);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
